uart_cmd_led: RTL and testbench
===============================

# uart_cmd_led

Frame parser and LED pattern engine that sits directly downstream of the UART byte receiver. It consumes `Rx_Data`/`Rx_Done` byte strobes and assembles 8-byte command frames: header `0x55 0xA5`, a 32-bit period, an 8-bit pattern, and tail `0xF0`. Each valid frame reloads the period and pattern registers. The LED steps through the 8 pattern bits, holding each bit for one period.

## Interface
- `DEFAULT_TIME`, 25_000_000: period in Clk cycles after reset; must be ≥1.
- `DEFAULT_CTRL`, 8'hAA: pattern after reset.
- `TIMEOUT_CYCLES`, 500_000: maximum allowed Clk cycles between bytes inside a frame.
- `Clk` input 1: single clock for the whole block.
- `Reset` input 1: synchronous, active-high reset.
- `Rx_Data` input 8: received byte; valid only in a cycle where `Rx_Done`=1.
- `Rx_Done` input 1: one-cycle byte strobe from the receiver.
- `Led` output 1: LED drive, registered.
- `Frame_Ok` output 1: one-cycle pulse when a frame is accepted.
- `Frame_Err` output 1: one-cycle pulse when a frame is rejected or times out.

## Operation
- Frame byte order: `0x55`, `0xA5`, T3, T2, T1, T0 (period, big-endian), C (pattern), `0xF0`.
- Parser states and transitions (each transition happens on a cycle with `Rx_Done`=1 unless stated):
  - S_HDR0: byte `0x55` → S_HDR1. Any other byte is ignored; no error pulse.
  - S_HDR1: byte `0xA5` → S_DATA, byte count cleared to 0. Byte `0x55` → stay in S_HDR1 (resync). Any other byte → S_HDR0, no error pulse.
  - S_DATA: shift the byte into a 40-bit shadow register (T3 first, C last) and increment the count. After the 5th byte → S_TAIL.
  - S_TAIL: byte `0xF0` with shadow period ≠ 0 → pulse `Frame_Ok`, load Time_r and Ctrl_r from the shadow, → S_HDR0.
  - S_TAIL: byte `0xF0` with shadow period = 0 → pulse `Frame_Err`, registers unchanged, → S_HDR0.
  - S_TAIL: any other byte → pulse `Frame_Err`, registers unchanged, → S_HDR0.
- Inter-byte timeout:
  - The gap counter clears on every `Rx_Done` and is held at 0 in S_HDR0.
  - In any other state it increments each cycle.
  - When it reaches `TIMEOUT_CYCLES`: → S_HDR0, pulse `Frame_Err`.
  - If `Rx_Done` arrives in the same cycle the limit is reached, the byte wins: it is processed and there is no timeout.
- LED engine:
  - `cnt` (32-bit) counts 0..Time_r−1 and wraps to 0.
  - On wrap, `phase` (3-bit) increments; it wraps from 7 to 0.
  - `Led` is registered from Ctrl_r[phase] every cycle.
  - On the `Frame_Ok` edge, `cnt` and `phase` are also forced to 0, so a new pattern always starts at bit 0.
- Period arithmetic: unsigned 32-bit compare of `cnt` against Time_r−1. Time_r=1 means the phase advances every cycle.

## Timing
- Reset values:
  - Parser state S_HDR0, count 0, shadow 0, gap counter 0.
  - Time_r=`DEFAULT_TIME`, Ctrl_r=`DEFAULT_CTRL`, `cnt`=0, `phase`=0.
  - `Led`=`DEFAULT_CTRL[0]`, `Frame_Ok`=0, `Frame_Err`=0.
- Assertion of `Reset` in any cycle, including mid-frame, restores all of the above on the next edge. The partial frame is discarded.
- `Frame_Ok`/`Frame_Err` are high exactly one cycle: the cycle after the edge that samples the tail byte `Rx_Done` (or the timeout).
- Time_r, Ctrl_r, `cnt` and `phase` update on that same edge.
- `Led` shows new Ctrl_r[0] one cycle after `Frame_Ok` rises.
- Each phase lasts exactly Time_r cycles on `Led`.
- Back-to-back `Rx_Done` on consecutive cycles must be accepted without loss.
- `Rx_Data` is ignored whenever `Rx_Done`=0.

## Structure
- Package `uart_led_pkg` holds:
  - Constants HDR0=8'h55, HDR1=8'hA5, TAIL=8'hF0, PAYLOAD_BYTES=5.
  - The parser state enum (S_HDR0, S_HDR1, S_DATA, S_TAIL).
- Sub-module `uart_led_pattern` holds the LED engine.
  - Inputs: Time_r, Ctrl_r, load pulse.
  - Output: `Led`.
  - Counters: `cnt`, `phase`.
- The top level `uart_cmd_led` holds the parser, shadow register, gap counter and Time_r/Ctrl_r registers.
- Gap counter width is $clog2(TIMEOUT_CYCLES+1).

## Test plan
- Valid frame test:
  - Parameters: `DEFAULT_TIME`=10, `TIMEOUT_CYCLES`=50.
  - Stimulus: frame 55 A5 00 00 00 04 C3 F0, bytes 5 cycles apart.
  - Required: one `Frame_Ok` pulse, no `Frame_Err`.
  - Required: `Led` sequence 1,1,0,0,0,0,1,1 (C3 read LSB first), each bit held 4 cycles, then repeating.
- Bad tail: 55 A5 00 00 00 04 C3 0F → one `Frame_Err` pulse. `Led` continues the default AA pattern with period 10, no phase reset.
- Zero period: 55 A5 00 00 00 00 FF F0 → `Frame_Err`, registers unchanged.
- Resync:
  - Stimulus: 55 55 A5 00 00 00 02 0F F0.
  - Required: `Frame_Ok`, Time_r=2, Ctrl_r=0x0F.
  - Also: stray bytes 12 34 before a header produce no pulses.
- Timeout and simultaneity:
  - 55 A5 00, then silence → `Frame_Err` after exactly 50 cycles, parser back in S_HDR0; a subsequent full valid frame is accepted.
  - A byte arriving on cycle 50 is processed instead of timing out.
- Reset mid-frame: assert `Reset` after 55 A5 00 00 → all outputs at reset values. A following frame's last four bytes alone (00 04 C3 F0) produce no pulse.

Source files
------------

// File: rtl/uart_led_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_led_pkg
//  Purpose  : Shared constants and parser state encoding for the UART command
//             frame parser and LED pattern engine.
//  Contents : HDR0/HDR1/TAIL frame marker bytes, PAYLOAD_BYTES, parse_state_e
//  Revision : 1.0 - initial release
// ============================================================================
package uart_led_pkg;

  localparam logic [7:0] HDR0          = 8'h55;
  localparam logic [7:0] HDR1          = 8'hA5;
  localparam logic [7:0] TAIL          = 8'hF0;
  localparam int         PAYLOAD_BYTES = 5;

  typedef enum logic [1:0] {
    S_HDR0 = 2'd0,
    S_HDR1 = 2'd1,
    S_DATA = 2'd2,
    S_TAIL = 2'd3
  } parse_state_e;

endpackage
`default_nettype wire

// File: rtl/uart_led_pattern.sv
`default_nettype none
// ============================================================================
//  Module   : uart_led_pattern
//  Purpose  : Steps the LED through the 8 bits of Ctrl_r, LSB first, holding
//             each bit for Time_r clock cycles.
//  Ports    : Clk, Reset  - clock, synchronous active-high reset
//             Time_r      - period in cycles (>= 1)
//             Ctrl_r      - 8-bit pattern
//             Load        - restart the pattern at bit 0 on this edge
//             Led         - registered LED drive
//  Revision : 1.0 - initial release
// ============================================================================
module uart_led_pattern #(
  parameter logic [7:0] DEFAULT_CTRL = 8'hAA
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] Time_r,
  input  logic [7:0]  Ctrl_r,
  input  logic        Load,
  output logic        Led
);

  logic [31:0] cnt_q, cnt_d;
  logic [2:0]  phase_q, phase_d;
  logic        led_q, led_d;
  logic        w_wrap;

  always_comb begin
    w_wrap  = (cnt_q == (Time_r - 32'd1));
    cnt_d   = w_wrap ? 32'd0 : cnt_q + 32'd1;
    phase_d = w_wrap ? phase_q + 3'd1 : phase_q;
    // A newly accepted frame always starts its pattern at bit 0.
    if (Load) begin
      cnt_d   = 32'd0;
      phase_d = 3'd0;
    end
    led_d = Ctrl_r[phase_q];
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt_q   <= 32'd0;
      phase_q <= 3'd0;
      led_q   <= DEFAULT_CTRL[0];
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      led_q   <= led_d;
    end
  end

  assign Led = led_q;

endmodule
`default_nettype wire

// File: rtl/uart_cmd_led.sv
`default_nettype none
// ============================================================================
//  Module   : uart_cmd_led
//  Purpose  : Assembles 8-byte command frames (55 A5 T3 T2 T1 T0 C F0) from
//             UART byte strobes and reloads the LED period/pattern registers.
//  Ports    : Clk, Reset          - clock, synchronous active-high reset
//             Rx_Data, Rx_Done    - received byte and its one-cycle strobe
//             Led                 - registered LED drive
//             Frame_Ok, Frame_Err - one-cycle accept / reject-or-timeout pulses
//  Revision : 1.0 - initial release
// ============================================================================
module uart_cmd_led
  import uart_led_pkg::*;
#(
  parameter logic [31:0] DEFAULT_TIME   = 32'd25_000_000,
  parameter logic [7:0]  DEFAULT_CTRL   = 8'hAA,
  parameter int          TIMEOUT_CYCLES = 500_000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] Rx_Data,
  input  logic       Rx_Done,
  output logic       Led,
  output logic       Frame_Ok,
  output logic       Frame_Err
);

  localparam int               GAP_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [GAP_W-1:0] GAP_LIMIT = GAP_W'(TIMEOUT_CYCLES);
  localparam logic [2:0]       LAST_DATA = 3'(PAYLOAD_BYTES - 1);

  parse_state_e     state_q, state_d;
  logic [2:0]       count_q, count_d;
  logic [39:0]      shadow_q, shadow_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [31:0]      time_q, time_d;
  logic [7:0]       ctrl_q, ctrl_d;
  logic             frame_ok_q, frame_ok_d;
  logic             frame_err_q, frame_err_d;
  logic             w_timeout;

  // The timeout fires on the edge where the gap count would reach the limit.
  // A byte strobe in that same cycle takes priority and suppresses it.
  assign w_timeout = (state_q != S_HDR0) && !Rx_Done &&
                     ((gap_q + GAP_W'(1)) == GAP_LIMIT);

  // State register
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= S_HDR0;
      count_q     <= 3'd0;
      shadow_q    <= 40'd0;
      gap_q       <= '0;
      time_q      <= DEFAULT_TIME;
      ctrl_q      <= DEFAULT_CTRL;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      shadow_q    <= shadow_d;
      gap_q       <= gap_d;
      time_q      <= time_d;
      ctrl_q      <= ctrl_d;
      frame_ok_q  <= frame_ok_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    shadow_d = shadow_q;
    gap_d    = gap_q + GAP_W'(1);
    if ((state_q == S_HDR0) || Rx_Done || w_timeout) begin
      gap_d = '0;
    end

    if (w_timeout) begin
      state_d = S_HDR0;
    end else if (Rx_Done) begin
      case (state_q)
        S_HDR0: begin
          if (Rx_Data == HDR0) state_d = S_HDR1;
        end
        S_HDR1: begin
          if (Rx_Data == HDR1) begin
            state_d = S_DATA;
            count_d = 3'd0;
          end else if (Rx_Data != HDR0) begin
            state_d = S_HDR0;
          end
        end
        S_DATA: begin
          // Period arrives big-endian, pattern last: shadow = {T3..T0, C}.
          shadow_d = {shadow_q[31:0], Rx_Data};
          count_d  = count_q + 3'd1;
          if (count_q == LAST_DATA) state_d = S_TAIL;
        end
        S_TAIL:  state_d = S_HDR0;
        default: state_d = S_HDR0;
      endcase
    end
  end

  // Output logic: frame verdict and register reload
  always_comb begin
    frame_ok_d  = 1'b0;
    frame_err_d = w_timeout;
    time_d      = time_q;
    ctrl_d      = ctrl_q;
    if (Rx_Done && (state_q == S_TAIL)) begin
      // A zero period would never wrap the LED counter, so it is rejected.
      if ((Rx_Data == TAIL) && (shadow_q[39:8] != 32'd0)) begin
        frame_ok_d = 1'b1;
        time_d     = shadow_q[39:8];
        ctrl_d     = shadow_q[7:0];
      end else begin
        frame_err_d = 1'b1;
      end
    end
  end

  // The load pulse is the combinational accept so the counters restart on the
  // same edge that loads the new period and pattern.
  uart_led_pattern #(
    .DEFAULT_CTRL (DEFAULT_CTRL)
  ) u_pattern (
    .Clk    (Clk),
    .Reset  (Reset),
    .Time_r (time_q),
    .Ctrl_r (ctrl_q),
    .Load   (frame_ok_d),
    .Led    (Led)
  );

  assign Frame_Ok  = frame_ok_q;
  assign Frame_Err = frame_err_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_led.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_cmd_led
//  Purpose  : Directed self-checking bench for uart_cmd_led. Expected frame
//             verdicts are queued as frames are sent and matched against the
//             Frame_Ok/Frame_Err pulses; Led is checked against a pattern model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_cmd_led;

  localparam int         T_DEF = 10;
  localparam int         TO    = 50;
  localparam logic [1:0] EV_OK  = 2'b01;
  localparam logic [1:0] EV_ERR = 2'b10;

  logic       Clk     = 1'b0;
  logic       Reset   = 1'b1;
  logic [7:0] Rx_Data = 8'h00;
  logic       Rx_Done = 1'b0;
  logic       Led;
  logic       Frame_Ok;
  logic       Frame_Err;

  int         n_tests  = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  int         base     = 0;
  logic [7:0] def_ctrl = 8'hAA;
  logic [1:0] sb[$];

  uart_cmd_led #(
    .DEFAULT_TIME   (32'd10),
    .DEFAULT_CTRL   (8'hAA),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Rx_Data   (Rx_Data),
    .Rx_Done   (Rx_Done),
    .Led       (Led),
    .Frame_Ok  (Frame_Ok),
    .Frame_Err (Frame_Err)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  // Every pulse must match the oldest queued verdict; a pulse with nothing
  // queued is unexpected.
  always @(negedge Clk) begin
    logic [1:0] obs;
    logic [1:0] expv;
    obs = {Frame_Err, Frame_Ok};
    if (obs != 2'b00) begin
      expv = (sb.size() > 0) ? sb.pop_front() : 2'b00;
      n_tests++;
      assert (obs === expv) else begin
        n_fail++;
        $error("FAIL pulse: observed {err,ok}=%b required %b", obs, expv);
      end
    end
  end

  function automatic logic led_model(logic [7:0] c, int t, int j);
    logic [2:0] idx;
    if (j < 1) idx = 3'd0;
    else       idx = 3'(((j - 1) / t) % 8);
    return c[idx];
  endfunction

  task automatic tick(int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic check(string tag, logic obs, logic expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %b required %b", tag, obs, expv);
    end
  endtask

  task automatic chk_sb(string tag);
    n_tests++;
    assert (sb.size() == 0) else begin
      n_fail++;
      $error("FAIL %s: pending pulses observed %0d required 0", tag, sb.size());
      sb.delete();
    end
  endtask

  task automatic chk_led(string tag, logic [7:0] c, int t, int b, int n);
    for (int k = 0; k < n; k++) begin
      tick(1);
      check(tag, Led, led_model(c, t, cyc - b));
    end
  endtask

  // Byte is sampled on the next edge; returns gap-1 cycles after that edge,
  // so the following byte is sampled exactly gap edges later.
  task automatic send_byte(logic [7:0] b, int gap);
    Rx_Data = b;
    Rx_Done = 1'b1;
    tick(1);
    Rx_Done = 1'b0;
    Rx_Data = 8'($urandom);
    if (gap > 1) tick(gap - 1);
  endtask

  // Returns just after the edge that sampled the tail byte.
  task automatic send_frame(logic [63:0] f, int gap);
    for (int i = 7; i >= 0; i--) send_byte(f[8*i +: 8], (i == 0) ? 1 : gap);
  endtask

  initial begin
    // Reset state
    Reset = 1'b1;
    tick(3);
    check("rst_led", Led, def_ctrl[0]);
    check("rst_ok", Frame_Ok, 1'b0);
    check("rst_err", Frame_Err, 1'b0);
    Reset = 1'b0;
    base  = cyc;

    // Stray bytes ahead of any header: no pulses
    send_byte(8'h12, 3);
    send_byte(8'h34, 3);

    // Bad tail: rejected, default pattern keeps running from reset
    sb.push_back(EV_ERR);
    send_frame(64'h55A5_0000_0004_C30F, 5);
    chk_led("badtail_led", def_ctrl, T_DEF, base, 30);
    chk_sb("badtail");

    // Zero period: rejected, registers unchanged
    sb.push_back(EV_ERR);
    send_frame(64'h55A5_0000_0000_FFF0, 5);
    chk_led("zero_led", def_ctrl, T_DEF, base, 25);
    chk_sb("zero");

    // Valid frame: period 4, pattern C3 starting at bit 0
    sb.push_back(EV_OK);
    send_frame(64'h55A5_0000_0004_C3F0, 5);
    base = cyc;
    chk_led("valid_led", 8'hC3, 4, base, 40);
    chk_sb("valid");

    // Resync on a repeated 0x55
    send_byte(8'h55, 3);
    sb.push_back(EV_OK);
    send_frame(64'h55A5_0000_0002_0FF0, 3);
    base = cyc;
    chk_led("resync_led", 8'h0F, 2, base, 20);
    chk_sb("resync");

    // Timeout after exactly TO silent cycles
    sb.push_back(EV_ERR);
    send_byte(8'h55, 2);
    send_byte(8'hA5, 2);
    send_byte(8'h00, 1);
    tick(TO - 1);
    check("to_early", Frame_Err, 1'b0);
    tick(1);
    check("to_fire", Frame_Err, 1'b1);
    tick(2);
    chk_sb("timeout");

    // Parser recovered: next frame accepted
    sb.push_back(EV_OK);
    send_frame(64'h55A5_0000_0003_81F0, 2);
    base = cyc;
    chk_led("after_to_led", 8'h81, 3, base, 24);
    chk_sb("after_to");

    // Each byte lands on the limit cycle: byte wins, frame accepted
    sb.push_back(EV_OK);
    send_byte(8'h55, 2);
    send_byte(8'hA5, 2);
    send_byte(8'h00, TO);
    send_byte(8'h00, TO);
    send_byte(8'h00, TO);
    send_byte(8'h02, TO);
    send_byte(8'h3C, TO);
    send_byte(8'hF0, 1);
    base = cyc;
    chk_led("edge_led", 8'h3C, 2, base, 16);
    chk_sb("edge");

    // Reset mid-frame discards the partial frame
    send_byte(8'h55, 2);
    send_byte(8'hA5, 2);
    send_byte(8'h00, 2);
    send_byte(8'h00, 2);
    Reset = 1'b1;
    tick(1);
    check("mrst_led", Led, def_ctrl[0]);
    check("mrst_ok", Frame_Ok, 1'b0);
    check("mrst_err", Frame_Err, 1'b0);
    Reset = 1'b0;
    base  = cyc;
    send_byte(8'h00, 2);
    send_byte(8'h04, 2);
    send_byte(8'hC3, 2);
    send_byte(8'hF0, 1);
    chk_led("postrst_led", def_ctrl, T_DEF, base, 25);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
